// File: rtl/dram_cmd_issuer.sv
// Pops timing-legal entries from the scheduler's issue FIFO onto a registered DRAM command bus.
// Optional busy-cycle counter output stall_cnt is built when ISSUER_STALL_CNT_EN is defined.
module dram_cmd_issuer #(
   parameter int CMD_W  = 4,
   parameter int ADDR_W = 14,
   parameter int BANK_W = 3,
   parameter int T_RCD  = 4,
   parameter int T_RAS  = 10,
   parameter int T_RP   = 4,
   parameter int T_RRD  = 2,
   parameter int T_CCD  = 2,
   parameter int T_RFC  = 20,
   parameter int TMR_W  = 6
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [CMD_W+ADDR_W+BANK_W-1:0]  fifo_data,
   input  logic                            fifo_empty,
   output logic                            fifo_ren,
   output logic                            dram_cmd_valid,
   output logic [CMD_W-1:0]                dram_cmd,
   output logic [ADDR_W-1:0]               dram_addr,
   output logic [BANK_W-1:0]               dram_bank,
   output logic                            illegal_cmd,
   output logic                            busy
`ifdef ISSUER_STALL_CNT_EN
   ,
   output logic [15:0]                     stall_cnt
`endif
);

   localparam int NUM_BANK = 2**BANK_W;

   localparam logic [CMD_W-1:0] C_NOP = CMD_W'(0);
   localparam logic [CMD_W-1:0] C_ACT = CMD_W'(1);
   localparam logic [CMD_W-1:0] C_RD  = CMD_W'(2);
   localparam logic [CMD_W-1:0] C_WR  = CMD_W'(3);
   localparam logic [CMD_W-1:0] C_PRE = CMD_W'(4);
   localparam logic [CMD_W-1:0] C_REF = CMD_W'(5);

   // Timers load T-1 so the dependent command decides exactly T cycles later.
   localparam logic [TMR_W-1:0] RCD_LD = TMR_W'(T_RCD - 1);
   localparam logic [TMR_W-1:0] RAS_LD = TMR_W'(T_RAS - 1);
   localparam logic [TMR_W-1:0] RP_LD  = TMR_W'(T_RP - 1);
   localparam logic [TMR_W-1:0] RRD_LD = TMR_W'(T_RRD - 1);
   localparam logic [TMR_W-1:0] CCD_LD = TMR_W'(T_CCD - 1);
   localparam logic [TMR_W-1:0] RFC_LD = TMR_W'(T_RFC - 1);

   typedef enum logic {S_IDLE, S_EVAL} state_t;

   state_t state, state_nxt;

   logic [CMD_W-1:0]  h_cmd;
   logic [ADDR_W-1:0] h_addr;
   logic [BANK_W-1:0] h_bank;

   logic [TMR_W-1:0] rcd_t [NUM_BANK];
   logic [TMR_W-1:0] ras_t [NUM_BANK];
   logic [TMR_W-1:0] rp_t  [NUM_BANK];
   logic [TMR_W-1:0] rrd_t, ccd_t, rfc_t;

   logic rp_any, legal, head;

   assign h_cmd  = fifo_data[ADDR_W+BANK_W +: CMD_W];
   assign h_addr = fifo_data[BANK_W +: ADDR_W];
   assign h_bank = fifo_data[BANK_W-1:0];

   function automatic logic [TMR_W-1:0] dec(input logic [TMR_W-1:0] t);
      return (t == '0) ? t : t - 1'b1;
   endfunction

   always_comb begin
      rp_any = 1'b0;
      for (int i = 0; i < NUM_BANK; i++) rp_any = rp_any | (rp_t[i] != '0);
   end

   always_comb begin
      legal = 1'b1;
      case (h_cmd)
         C_ACT:      legal = (rp_t[h_bank] == '0) && (rrd_t == '0) && (rfc_t == '0);
         C_RD, C_WR: legal = (rcd_t[h_bank] == '0) && (ccd_t == '0);
         C_PRE:      legal = (ras_t[h_bank] == '0);
         C_REF:      legal = !rp_any && (rfc_t == '0);
         default:    legal = 1'b1;
      endcase
   end

   // Reset gates the combinational outputs so nothing pops while rst_n is low.
   assign head = rst_n && !fifo_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // S_IDLE also decides, so an entry arriving after a gap issues in its first cycle.
   always_comb begin
      state_nxt = state;
      fifo_ren  = 1'b0;
      busy      = 1'b0;
      case (state)
         S_IDLE: begin
            if (head) begin
               fifo_ren  = legal;
               busy      = !legal;
               state_nxt = S_EVAL;
            end
         end
         S_EVAL: begin
            fifo_ren  = head && legal;
            busy      = head && !legal;
            state_nxt = head ? S_EVAL : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_BANK; i++) begin
            rcd_t[i] <= '0;
            ras_t[i] <= '0;
            rp_t[i]  <= '0;
         end
         rrd_t <= '0;
         ccd_t <= '0;
         rfc_t <= '0;
      end else begin
         for (int i = 0; i < NUM_BANK; i++) begin
            rcd_t[i] <= dec(rcd_t[i]);
            ras_t[i] <= dec(ras_t[i]);
            rp_t[i]  <= dec(rp_t[i]);
         end
         rrd_t <= dec(rrd_t);
         ccd_t <= dec(ccd_t);
         rfc_t <= dec(rfc_t);
         if (fifo_ren) begin
            case (h_cmd)
               C_ACT: begin
                  rcd_t[h_bank] <= RCD_LD;
                  ras_t[h_bank] <= RAS_LD;
                  rrd_t         <= RRD_LD;
               end
               C_RD, C_WR: ccd_t        <= CCD_LD;
               C_PRE:      rp_t[h_bank] <= RP_LD;
               C_REF:      rfc_t        <= RFC_LD;
               default: ;
            endcase
         end
      end
   end

   // NOP and illegal pops leave a bubble; addr/bank keep their last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dram_cmd_valid <= 1'b0;
         dram_cmd       <= C_NOP;
         dram_addr      <= '0;
         dram_bank      <= '0;
         illegal_cmd    <= 1'b0;
      end else begin
         dram_cmd_valid <= 1'b0;
         dram_cmd       <= C_NOP;
         if (fifo_ren) begin
            if (h_cmd >= C_ACT && h_cmd <= C_REF) begin
               dram_cmd_valid <= 1'b1;
               dram_cmd       <= h_cmd;
               dram_addr      <= h_addr;
               dram_bank      <= h_bank;
            end else if (h_cmd != C_NOP) begin
               illegal_cmd <= 1'b1;
            end
         end
      end
   end

`ifdef ISSUER_STALL_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           stall_cnt <= '0;
      else if (busy && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_dram_cmd_issuer.sv
// Directed and random checks of dram_cmd_issuer against a timestamp-based reference model.
module tb_dram_cmd_issuer;
   localparam int T_RCD = 4, T_RAS = 10, T_RP = 4, T_RRD = 2, T_CCD = 2, T_RFC = 20;
   localparam int NB = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [20:0] fifo_data;
   logic        fifo_empty;
   logic        fifo_ren, dram_cmd_valid, illegal_cmd, busy;
   logic [3:0]  dram_cmd;
   logic [13:0] dram_addr;
   logic [2:0]  dram_bank;
`ifdef ISSUER_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   dram_cmd_issuer dut (
      .clk(clk), .rst_n(rst_n), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
      .fifo_ren(fifo_ren), .dram_cmd_valid(dram_cmd_valid), .dram_cmd(dram_cmd),
      .dram_addr(dram_addr), .dram_bank(dram_bank), .illegal_cmd(illegal_cmd),
      .busy(busy)
`ifdef ISSUER_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_err = 0;
   int cyc;
   logic [20:0] q[$];
   int bus_cyc[$];
   int bus_cmd[$];

   // Reference state: cycle in which each kind of command was last decided.
   int t_act[NB], t_pre[NB], t_act_any, t_col, t_ref;
   logic        e_valid, e_ill;
   logic [3:0]  e_cmd;
   logic [13:0] e_addr;
   logic [2:0]  e_bank;
   int          e_stall;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [20:0] mk(input int c, input int a, input int b);
      return {4'(c), 14'(a), 3'(b)};
   endfunction

   function automatic int at(input int i);
      return (bus_cyc.size() > i) ? bus_cyc[i] : -99999;
   endfunction

   task automatic model_reset();
      for (int b = 0; b < NB; b++) begin t_act[b] = -1000; t_pre[b] = -1000; end
      t_act_any = -1000; t_col = -1000; t_ref = -1000;
      e_valid = 0; e_ill = 0; e_cmd = 0; e_addr = 0; e_bank = 0; e_stall = 0;
   endtask

   function automatic bit m_legal(input logic [20:0] e);
      int c, b;
      bit ok;
      c = int'(e[20:17]); b = int'(e[2:0]);
      case (c)
         1: return (cyc - t_pre[b] >= T_RP) && (cyc - t_act_any >= T_RRD) && (cyc - t_ref >= T_RFC);
         2, 3: return (cyc - t_act[b] >= T_RCD) && (cyc - t_col >= T_CCD);
         4: return (cyc - t_act[b] >= T_RAS);
         5: begin
            ok = (cyc - t_ref >= T_RFC);
            for (int i = 0; i < NB; i++) if (cyc - t_pre[i] < T_RP) ok = 0;
            return ok;
         end
         default: return 1;
      endcase
   endfunction

   // One cycle: check registered outputs, drive head, check ren/busy, advance model.
   task automatic step();
      logic [20:0] e;
      bit lg;
      int c;
      chk("valid", dram_cmd_valid, e_valid);
      chk("cmd", dram_cmd, e_cmd);
      chk("addr", dram_addr, e_addr);
      chk("bank", dram_bank, e_bank);
      chk("illegal", illegal_cmd, e_ill);
`ifdef ISSUER_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, e_stall);
`endif
      if (dram_cmd_valid) begin bus_cyc.push_back(cyc); bus_cmd.push_back(int'(dram_cmd)); end
      if (q.size() > 0) begin fifo_empty = 0; fifo_data = q[0]; end
      else begin fifo_empty = 1; fifo_data = 21'($urandom); end
      #1;
      e = fifo_data;
      lg = m_legal(e);
      chk("fifo_ren", fifo_ren, !fifo_empty && lg);
      chk("busy", busy, !fifo_empty && !lg);
      e_valid = 0; e_cmd = 0;
      if (!fifo_empty && lg) begin
         void'(q.pop_front());
         c = int'(e[20:17]);
         case (c)
            1: begin t_act[e[2:0]] = cyc; t_act_any = cyc; end
            2, 3: t_col = cyc;
            4: t_pre[e[2:0]] = cyc;
            5: t_ref = cyc;
            0: ;
            default: e_ill = 1;
         endcase
         if (c >= 1 && c <= 5) begin
            e_valid = 1; e_cmd = e[20:17]; e_addr = e[16:3]; e_bank = e[2:0];
         end
      end else if (!fifo_empty && e_stall < 16'hFFFF) e_stall++;
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   int rel, r, base;

   initial begin
      rst_n = 0; fifo_empty = 1; fifo_data = '0;
      model_reset();
      cyc = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", dram_cmd_valid, 0);
      chk("rst_cmd", dram_cmd, 0);
      chk("rst_ren", fifo_ren, 0);
      chk("rst_busy", busy, 0);
      chk("rst_illegal", illegal_cmd, 0);
      rst_n = 1;

      // ACT b2 then RD b2: bus at 1 and 1+T_RCD
      base = cyc; bus_cyc.delete(); bus_cmd.delete();
      q.push_back(mk(1, 16'h0123, 2)); q.push_back(mk(2, 16'h0010, 2));
      run(10);
      chk("s1_act_cycle", at(0) - base, 1);
      chk("s1_rd_cycle", at(1) - base, 5);

      // ACT b0, ACT b1, PRE b0, ACT b0
      run(25); bus_cyc.delete(); bus_cmd.delete();
      q.push_back(mk(1, 5, 0)); q.push_back(mk(1, 6, 1));
      q.push_back(mk(4, 0, 0)); q.push_back(mk(1, 7, 0));
      run(20);
      chk("s2_rrd", at(1) - at(0), T_RRD);
      chk("s2_ras", at(2) - at(0), T_RAS);
      chk("s2_rp", at(3) - at(2), T_RP);

      // RD, RD, WR on bank 0
      run(25); bus_cyc.delete(); bus_cmd.delete();
      q.push_back(mk(2, 1, 0)); q.push_back(mk(2, 2, 0)); q.push_back(mk(3, 3, 0));
      run(10);
      chk("s3_ccd_a", at(1) - at(0), T_CCD);
      chk("s3_ccd_b", at(2) - at(1), T_CCD);

      // PRE b1, REF (held by rp), ACT b3 (held by rfc)
      run(25); bus_cyc.delete(); bus_cmd.delete();
      q.push_back(mk(4, 0, 1)); q.push_back(mk(5, 0, 0)); q.push_back(mk(1, 9, 3));
      run(32);
      chk("s4_ref_after_rp", at(1) - at(0), T_RP);
      chk("s4_rfc", at(2) - at(1), T_RFC);

      // illegal, NOP, RD
      run(25); bus_cyc.delete(); bus_cmd.delete();
      q.push_back(mk(10, 1, 1)); q.push_back(mk(0, 2, 2)); q.push_back(mk(2, 3, 0));
      run(8);
      chk("s5_bus_count", bus_cyc.size(), 1);
      chk("s5_bus_cmd", (bus_cmd.size() > 0) ? bus_cmd[0] : -1, 2);
      chk("s5_illegal_sticky", illegal_cmd, 1);

      // async reset in the middle of an RFC wait
      run(25);
      q.push_back(mk(5, 0, 0)); q.push_back(mk(1, 11, 3));
      step();
      chk("s6_ref_on_bus", dram_cmd_valid, 1);
      run(5);
      chk("s6_busy_before_rst", busy, 1);
      #2; rst_n = 0; #1;
      chk("s6_rst_valid", dram_cmd_valid, 0);
      chk("s6_rst_cmd", dram_cmd, 0);
      chk("s6_rst_addr", dram_addr, 0);
      chk("s6_rst_illegal", illegal_cmd, 0);
      chk("s6_rst_busy", busy, 0);
      chk("s6_rst_ren", fifo_ren, 0);
      @(posedge clk); #1;
      rst_n = 1;
      model_reset();
      cyc++;
      rel = cyc; bus_cyc.delete(); bus_cmd.delete();
      run(3);
      chk("s6_act_after_rst", at(0) - rel, 1);

      // random traffic
      run(25);
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 1) == 1 && q.size() < 16) begin
            r = $urandom_range(0, 15);
            case (r)
               0, 1, 2, 3, 15: q.push_back(mk(1, $urandom, $urandom));
               4, 5, 6: q.push_back(mk(2, $urandom, $urandom));
               7, 8: q.push_back(mk(3, $urandom, $urandom));
               9, 10, 11: q.push_back(mk(4, $urandom, $urandom));
               12: q.push_back(mk(5, $urandom, $urandom));
               13: q.push_back(mk(0, $urandom, $urandom));
               default: q.push_back(mk($urandom_range(6, 15), $urandom, $urandom));
            endcase
         end
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/dram_cmd_issuer.md
Name: dram_cmd_issuer

Overview:
- Downstream consumer of the command scheduler's issue FIFO. Reads the show-ahead head entry {command, addr, bank}, enforces DRAM timing per bank and globally, and pops the entry only when it is legal to issue.
- Drives a registered single-command-per-cycle DRAM command bus to the PHY side.
- This is the point where scheduled commands become timing-correct bus commands.

Parameters:
- CMD_W, 4, command field width (entry bits [20:17])
- ADDR_W, 14, address field width (entry bits [16:3])
- BANK_W, 3, bank field width (entry bits [2:0]); NUM_BANK = 2**BANK_W
- T_RCD, 4, ACT to RD/WR, same bank (cycles)
- T_RAS, 10, ACT to PRE, same bank
- T_RP, 4, PRE to ACT, same bank
- T_RRD, 2, ACT to ACT, any bank
- T_CCD, 2, column command to column command, any bank
- T_RFC, 20, REF to any ACT
- TMR_W, 6, timer width; every T_* must be <= 2**TMR_W-1

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- fifo_data  input  CMD_W+ADDR_W+BANK_W  head entry of the issue FIFO (show-ahead, valid when !fifo_empty)
- fifo_empty  input  1  issue FIFO empty
- fifo_ren  output  1  pop request; combinational
- dram_cmd_valid  output  1  command on bus this cycle; registered
- dram_cmd  output  CMD_W  command code; registered
- dram_addr  output  ADDR_W  row/column address; registered
- dram_bank  output  BANK_W  bank; registered
- illegal_cmd  output  1  sticky: an unknown encoding was popped
- busy  output  1  head present but blocked by timing

Behaviour:
- Reset: one clock, clk; rst_n asynchronous active-low. All outputs 0, dram_cmd = NOP (0). All timers 0, FSM in S_IDLE, illegal_cmd cleared. Assertion mid-operation aborts immediately; no partial command is emitted.
- Encodings: NOP=0, ACT=1, RD=2, WR=3, PRE=4, REF=5. All other values are illegal.
- Timers: per-bank rcd_t[b], ras_t[b], rp_t[b]; global rrd_t, ccd_t, rfc_t.
  - When a command is decided in cycle c, each dependent timer loads T-1 at the end of c, then decrements by 1 per cycle and saturates at 0.
  - A timer at 0 means satisfied, so the dependent command reaches the bus no earlier than c+1+T.
- Legality of the head entry:
  - ACT(b): rp_t[b]==0, rrd_t==0, rfc_t==0.
  - RD/WR(b): rcd_t[b]==0, ccd_t==0.
  - PRE(b): ras_t[b]==0.
  - REF: rp_t[all]==0, rfc_t==0.
  - NOP: always legal.
  - Illegal encoding: always legal to pop.
- Timer loads on issue:
  - ACT loads rcd_t[b], ras_t[b], rrd_t.
  - RD/WR loads ccd_t.
  - PRE loads rp_t[b].
  - REF loads rfc_t.
- FSM states:
  - S_IDLE: fifo_empty=1. Go to S_EVAL when !fifo_empty.
  - S_EVAL: head present. If legal: fifo_ren=1 and the entry is captured into the output registers. Stay in S_EVAL if more entries remain, else return to S_IDLE. FIFO emptiness is sampled each cycle.
  - If not legal: fifo_ren=0, busy=1, stay in S_EVAL.
- Latency: decision in cycle c puts dram_cmd_valid=1 with the command in cycle c+1. Back-to-back legal entries issue one per cycle.
- fifo_ren is never asserted while fifo_empty=1.
- NOP entries are popped and produce dram_cmd_valid=0 with dram_cmd=NOP (bubble).
- Illegal entries are popped, dropped with dram_cmd_valid=0, and set illegal_cmd until reset.
- Outputs hold their last addr/bank when valid=0; dram_cmd returns to NOP.
- Head entry may change while blocked (the FIFO may not, but tolerate it). Legality is re-evaluated every cycle from current fifo_data.

Optional Feature:
- Macro ISSUER_STALL_CNT_EN.
- Defined: adds output stall_cnt [15:0], which counts cycles with busy=1, saturates at 16'hFFFF, and resets to 0.
- Undefined: no port, no counter logic.

Test Plan:
- Single ACT b2 row 0x0123 then RD b2 col 0x0010 in FIFO at t=0:
  - ACT valid at cycle 1.
  - RD valid at cycle 1+T_RCD=5.
  - busy=1 for cycles 1..3.
  - fifo_ren pulses at cycles 0 and 4.
- ACT b0, ACT b1 back-to-back:
  - Second ACT appears exactly T_RRD=2 cycles after the first.
  - Then ACT b0 again after PRE b0: PRE no earlier than 10 cycles after ACT b0; ACT b0 4 cycles after PRE.
- RD b0, RD b0, WR b0 with rcd satisfied: column commands spaced 2 cycles apart (cycles n, n+2, n+4).
- REF issued, then ACT b3 queued:
  - ACT b3 is not valid until 20 cycles after REF.
  - REF is held while any bank's rp_t is nonzero.
- Entry with cmd=4'hA, then NOP, then RD:
  - illegal_cmd rises the cycle after pop and stays high.
  - No bus valid for either of the first two entries.
  - RD issues normally.
- rst_n driven low asynchronously mid-way through a T_RFC wait: outputs clear immediately without a clock edge. After release, the queued ACT issues at the first legal cycle with no residual RFC wait.
